// File: rtl/input_fifo.sv
// input_fifo: first-word-fall-through FIFO for wl_bitmap words passed from the DMA
// engine to the SNN core controller. It also has a small MMIO window that reports
// status, holds sticky overflow/underflow flags and a high-water mark, and accepts
// a software flush command.
module input_fifo #(
    parameter int WIDTH = 64,               // snn_soc_pkg::NUM_INPUTS
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    // producer side (DMA)
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    // consumer side (core controller)
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count,
    // MMIO register window
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic [31:0]      reg_rdata
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_DEPTH  = 8'h08;

    // The pointers wrap naturally only for a power-of-two depth, and the count and
    // hwm fields of STATUS are 8 bits wide.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH > 128)) begin : g_bad_depth
        $error("input_fifo: DEPTH must be a power of two between 2 and 128");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] hwm_q, hwm_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic wr_en;
    logic status_wr;
    logic flush;
    logic ovf_clr;
    logic unf_clr;
    logic hwm_clr;
    logic eff_push;
    logic eff_pop;
    logic ovf_set;
    logic unf_set;

    // These request bits carry no meaning: every register is bit-command.
    logic unused_req_bits;
    assign unused_req_bits = ^{req_wstrb, req_addr[31:8], req_wdata[31:5], req_wdata[1]};

    // Decode MMIO writes into flush and W1C commands.
    always_comb begin
        wr_en     = req_valid && req_write;
        status_wr = wr_en && (req_addr[7:0] == ADDR_STATUS);
        flush     = wr_en && (req_addr[7:0] == ADDR_CTRL) && req_wdata[0];
        ovf_clr   = status_wr && req_wdata[2];
        unf_clr   = status_wr && req_wdata[3];
        hwm_clr   = status_wr && req_wdata[4];
    end

    // Status flags are taken from the registered occupancy.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        count = count_q;
    end

    // A push into a full FIFO is accepted only when a pop frees a slot on the same
    // edge. A flush cancels both sides and raises no flags.
    always_comb begin
        eff_push = push && (!full || pop) && !flush;
        eff_pop  = pop && !empty && !flush;
        ovf_set  = push && full && !pop && !flush;
        unf_set  = pop && empty && !flush;
    end

    // Next state for the pointers, occupancy, sticky flags and high-water mark.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        hwm_d       = hwm_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (eff_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (eff_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(eff_push) - CW'(eff_pop);
        end

        // When a new event coincides with a W1C write, the event wins.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        if (unf_set) begin
            underflow_d = 1'b1;
        end else if (unf_clr) begin
            underflow_d = 1'b0;
        end

        // Clearing the mark restarts it from the occupancy of the coming cycle, so
        // an occupancy reached on the same edge is still recorded.
        if (hwm_clr) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    // Control and status state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            hwm_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            hwm_q       <= hwm_d;
        end
    end

    // Storage array. It is not reset: the count marks which entries are valid.
    always_ff @(posedge clk) begin
        if (eff_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // The head entry falls through to rdata. It reads as zero while the FIFO is empty.
    always_comb begin
        rdata = '0;
        if (!empty) begin
            rdata = mem_q[rd_ptr_q];
        end
    end

    // Combinational MMIO read mux.
    always_comb begin
        reg_rdata = '0;
        case (req_addr[7:0])
            ADDR_STATUS: reg_rdata = {8'h00, 8'(hwm_q), 8'(count_q), 4'h0,
                                      underflow_q, overflow_q, full, empty};
            ADDR_DEPTH:  reg_rdata = 32'(DEPTH);
            default:     reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_input_fifo.sv
// Directed testbench for input_fifo with DEPTH=16 and WIDTH=64.
module tb_input_fifo;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [63:0] wdata;
    logic        full;
    logic        pop;
    logic [63:0] rdata;
    logic        empty;
    logic [4:0]  count;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] reg_rdata;

    int total;
    int bad;

    input_fifo #(.WIDTH(64), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .wdata     (wdata),
        .full      (full),
        .pop       (pop),
        .rdata     (rdata),
        .empty     (empty),
        .count     (count),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .reg_rdata (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 32'h0;
    endtask

    task automatic mmio_rd(input logic [31:0] a, output logic [31:0] v);
        req_addr = a;
        #1;
        v = reg_rdata;
    endtask

    function automatic logic [63:0] word_w(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 3);
    endfunction

    function automatic logic [63:0] word_b(input int i);
        return {32'hB0B0_0000 | 32'(i), 32'h1234_0000 + 32'(i)};
    endfunction

    function automatic logic [63:0] word_d(input int i);
        return {32'hD0A0_0000 | 32'(i), 32'h5A5A_0000 + 32'(i * 3)};
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        #2;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h0000_0001) begin bad++; $display("FAIL rst_status got=%h exp=00000001", v); end
        mmio_rd(32'h8, v);
        total++; if (v !== 32'd16) begin bad++; $display("FAIL depth_reg got=%0d exp=16", v); end
        mmio_rd(32'h4, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ctrl_reads0 got=%h exp=0", v); end
        mmio_rd(32'h1C, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL other_addr got=%h exp=0", v); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] v;
        wdata = 64'h0123_4567_89AB_CDEF;
        push  = 1'b1;
        tick();
        push = 1'b0;
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", empty); end
        total++; if (rdata !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL single_rdata got=%h exp=0123456789abcdef", rdata); end
        total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", count); end
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h0001_0001) begin bad++; $display("FAIL single_status got=%h exp=00010001", v); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] v;
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = word_w(i);
            tick();
        end
        push = 1'b0;
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", count); end
        push  = 1'b1;
        wdata = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        push = 1'b0;
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
        mmio_rd(32'h0, v);
        total++; if (v[2] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", v[2]); end
        pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (rdata !== word_w(i)) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, rdata, word_w(i)); end
            tick();
        end
        pop = 1'b0;
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h0010_0005) begin bad++; $display("FAIL drain_status got=%h exp=00100005", v); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        mmio_wr(32'h0, 32'h1C);
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h0000_0001) begin bad++; $display("FAIL w1c_all got=%h exp=00000001", v); end
        push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = word_b(i);
            tick();
        end
        wdata = 64'hFEED_0000_0000_0016;
        pop   = 1'b1;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        total++; if (count !== 5'd16) begin bad++; $display("FAIL pp_full_count got=%0d exp=16", count); end
        total++; if (rdata !== word_b(1)) begin bad++; $display("FAIL pp_full_head got=%h exp=%h", rdata, word_b(1)); end
        mmio_rd(32'h0, v);
        total++; if (v[3:2] !== 2'b00) begin bad++; $display("FAIL pp_full_flags got=%b exp=00", v[3:2]); end
        pop = 1'b1;
        for (int i = 1; i < 16; i++) begin
            total++; if (rdata !== word_b(i)) begin bad++; $display("FAIL pp_drain[%0d] got=%h exp=%h", i, rdata, word_b(i)); end
            tick();
        end
        total++; if (rdata !== 64'hFEED_0000_0000_0016) begin bad++; $display("FAIL pp_last got=%h exp=feed000000000016", rdata); end
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL pp_drained got=%b exp=1", empty); end
        push  = 1'b1;
        wdata = 64'hE0E0_E0E0_0000_0001;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        total++; if (count !== 5'd1) begin bad++; $display("FAIL pp_empty_count got=%0d exp=1", count); end
        total++; if (rdata !== 64'hE0E0_E0E0_0000_0001) begin bad++; $display("FAIL pp_empty_data got=%h exp=e0e0e0e000000001", rdata); end
        mmio_rd(32'h0, v);
        total++; if (v[3] !== 1'b1) begin bad++; $display("FAIL pp_empty_unf got=%b exp=1", v[3]); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] v;
        mmio_wr(32'h0, 32'h1C);
        pop = 1'b1;
        tick();
        pop  = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = word_w(40 + i);
            tick();
        end
        wdata     = 64'h1111_2222_3333_4444;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h4;
        req_wdata = 32'h1;
        tick();
        push      = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h0005_0009) begin bad++; $display("FAIL flush_status got=%h exp=00050009", v); end
        push  = 1'b1;
        wdata = 64'h7777_0000_0000_7777;
        tick();
        push = 1'b0;
        total++; if (rdata !== 64'h7777_0000_0000_7777) begin bad++; $display("FAIL post_flush_data got=%h exp=7777000000007777", rdata); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_w1c();
        logic [31:0] v;
        mmio_wr(32'h0, 32'h1C);
        push = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wdata = word_b(100 + i);
            tick();
        end
        mmio_rd(32'h0, v);
        total++; if (v[2] !== 1'b1) begin bad++; $display("FAIL w1c_pre_ovf got=%b exp=1", v[2]); end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'h4;
        tick();
        push      = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wdata = 32'h0;
        mmio_rd(32'h0, v);
        total++; if (v[2] !== 1'b1) begin bad++; $display("FAIL w1c_set_wins got=%b exp=1", v[2]); end
        mmio_wr(32'h0, 32'h4);
        mmio_rd(32'h0, v);
        total++; if (v[2] !== 1'b0) begin bad++; $display("FAIL w1c_ovf_clear got=%b exp=0", v[2]); end
        pop = 1'b1;
        repeat (3) tick();
        pop = 1'b0;
        mmio_wr(32'h0, 32'h10);
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h000D_0D00) begin bad++; $display("FAIL hwm_clear got=%h exp=000d0d00", v); end
        mmio_wr(32'h4, 32'h1);
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h000D_0001) begin bad++; $display("FAIL flush_keeps_hwm got=%h exp=000d0001", v); end
    endtask

    task automatic test_dma_stream();
        logic [31:0] v;
        int sent;
        int got;
        sent = 0;
        got  = 0;
        mmio_wr(32'h0, 32'h1C);
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            push  = ((cyc % 2) == 0) && !full && (sent < 8);
            wdata = word_d(sent);
            pop   = ((cyc % 3) == 2) && !empty;
            if (pop) begin
                total++; if (rdata !== word_d(got)) begin bad++; $display("FAIL dma_data[%0d] got=%h exp=%h", got, rdata, word_d(got)); end
                got++;
            end
            if (push) sent++;
            tick();
        end
        push = 1'b0;
        pop  = 1'b0;
        total++; if (got !== 8) begin bad++; $display("FAIL dma_delivered got=%0d exp=8", got); end
        mmio_rd(32'h0, v);
        total++; if (v[15:0] !== 16'h0001) begin bad++; $display("FAIL dma_status got=%h exp=0001", v[15:0]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = word_w(200 + i);
            tick();
        end
        push = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b exp=1", empty); end
        mmio_rd(32'h0, v);
        total++; if (v !== 32'h0000_0001) begin bad++; $display("FAIL midrst_status got=%h exp=00000001", v); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        wdata     = 64'h0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_wstrb = 4'hF;
        test_reset();
        test_single();
        test_fill_wrap();
        test_simultaneous();
        test_flush();
        test_w1c();
        test_dma_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
